// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, EX mispredict, multi-cycle FPU, cache misses.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int FPU_LAT = 4,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_fpu_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mispredict,
  input  logic              icache_miss,
  input  logic              dcache_miss,
  output logic              pc_hold,
  output logic              Reg_IF_ID_remain,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_hold,
  output logic [1:0]        ctrl_state,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FPU_WAIT = 2'd2;

  localparam logic [3:0] FPU_INIT = 4'(FPU_LAT - 1);

  logic [1:0] state, state_nxt;
  logic [3:0] fpu_cnt, fpu_cnt_nxt;
  logic       pend, pend_nxt;
  logic       load_use;
  logic       ph, rem, fl, bub, emh;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt   = state;
    fpu_cnt_nxt = fpu_cnt;
    pend_nxt    = pend;
    ph  = 1'b0;
    rem = 1'b0;
    fl  = 1'b0;
    bub = 1'b0;
    emh = 1'b0;
    case (state)
      RUN: begin
        if (dcache_miss) begin
          ph        = 1'b1;
          rem       = 1'b1;
          emh       = 1'b1;
          state_nxt = MEM_WAIT;
          pend_nxt  = ex_mispredict;
        end else if (ex_mispredict) begin
          fl  = 1'b1;
          bub = 1'b1;
        end else if (id_fpu_op) begin
          // The issue cycle itself does not stall; a 1-cycle op never leaves RUN.
          if (FPU_LAT > 1) begin
            state_nxt   = FPU_WAIT;
            fpu_cnt_nxt = FPU_INIT;
          end
        end else if (load_use) begin
          ph  = 1'b1;
          rem = 1'b1;
          bub = 1'b1;
        end else if (icache_miss) begin
          ph = 1'b1;
          fl = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX is frozen, so a mispredict seen here re-asserts later and is ignored.
        if (dcache_miss) begin
          ph  = 1'b1;
          rem = 1'b1;
          emh = 1'b1;
        end else begin
          state_nxt = RUN;
          pend_nxt  = 1'b0;
          if (pend) begin
            fl  = 1'b1;
            bub = 1'b1;
          end
        end
      end
      FPU_WAIT: begin
        ph  = 1'b1;
        rem = 1'b1;
        bub = 1'b1;
        if (dcache_miss) begin
          emh = 1'b1;
        end else if (fpu_cnt <= 4'd1) begin
          state_nxt   = RUN;
          fpu_cnt_nxt = '0;
        end else begin
          fpu_cnt_nxt = fpu_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt   = RUN;
        fpu_cnt_nxt = '0;
        pend_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      fpu_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      state   <= state_nxt;
      fpu_cnt <= fpu_cnt_nxt;
      pend    <= pend_nxt;
    end
  end

  // Outputs are forced low while reset is held, independent of the hazard inputs.
  assign pc_hold          = rst & ph;
  assign if_id_flush      = rst & fl;
  assign Reg_IF_ID_remain = rst & rem & ~fl;
  assign id_ex_bubble     = rst & bub;
  assign ex_mem_hold      = rst & emh;
  assign ctrl_state       = state;

`ifdef HAZARD_PERF_CNT_EN
  logic mp_flush;
  assign mp_flush = ~dcache_miss &
                    (((state == RUN) & ex_mispredict) | ((state == MEM_WAIT) & pend));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold)  stall_cnt <= stall_cnt + 32'd1;
      if (mp_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random bench for pipeline_hazard_ctrl against a cycles-remaining reference model.
module tb_pipeline_hazard_ctrl;
  localparam int FPU_LAT = 4;
  localparam int REG_AW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, id_fpu_op, ex_mem_read, ex_mispredict, icache_miss, dcache_miss;
  logic pc_hold, Reg_IF_ID_remain, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.FPU_LAT(FPU_LAT), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_fpu_op(id_fpu_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mispredict(ex_mispredict), .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .pc_hold(pc_hold), .Reg_IF_ID_remain(Reg_IF_ID_remain), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: "in a D-cache wait", "FPU stall cycles still owed", "flush owed".
  bit          m_mem_wait;
  int          m_fpu_left;
  bit          m_pend;
  logic [31:0] m_stall, m_flush;
  logic e_ph, e_rem, e_fl, e_bub, e_emh, e_mpf;
  logic [1:0] e_st;
  int fpu_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mem_wait = 0; m_fpu_left = 0; m_pend = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_outputs();
    logic lu;
    e_ph = 0; e_rem = 0; e_fl = 0; e_bub = 0; e_emh = 0; e_mpf = 0;
    e_st = m_mem_wait ? 2'd1 : (m_fpu_left > 0) ? 2'd2 : 2'd0;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst) begin
      if (m_mem_wait) begin
        if (dcache_miss) begin e_ph = 1; e_rem = 1; e_emh = 1; end
        else if (m_pend) begin e_fl = 1; e_bub = 1; e_mpf = 1; end
      end else if (m_fpu_left > 0) begin
        e_ph = 1; e_rem = 1; e_bub = 1; e_emh = dcache_miss;
      end else if (dcache_miss) begin
        e_ph = 1; e_rem = 1; e_emh = 1;
      end else if (ex_mispredict) begin
        e_fl = 1; e_bub = 1; e_mpf = 1;
      end else if (id_fpu_op) begin
        e_ph = 0;
      end else if (lu) begin
        e_ph = 1; e_rem = 1; e_bub = 1;
      end else if (icache_miss) begin
        e_ph = 1; e_fl = 1;
      end
    end
  endtask

  task automatic model_tick();
    m_stall = m_stall + 32'(e_ph);
    m_flush = m_flush + 32'(e_mpf);
    if (m_mem_wait) begin
      if (!dcache_miss) begin m_mem_wait = 0; m_pend = 0; end
    end else if (m_fpu_left > 0) begin
      if (!dcache_miss) m_fpu_left--;
    end else if (dcache_miss) begin
      m_mem_wait = 1; m_pend = ex_mispredict;
    end else if (!ex_mispredict && id_fpu_op) begin
      m_fpu_left = FPU_LAT - 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_hold"}, 32'(pc_hold), 32'(e_ph));
    chk({tag, ".remain"},  32'(Reg_IF_ID_remain), 32'(e_rem));
    chk({tag, ".flush"},   32'(if_id_flush), 32'(e_fl));
    chk({tag, ".bubble"},  32'(id_ex_bubble), 32'(e_bub));
    chk({tag, ".exmem"},   32'(ex_mem_hold), 32'(e_emh));
    chk({tag, ".state"},   32'(ctrl_state), 32'(e_st));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
`else
    chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, ".flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    model_outputs();
    check_all(tag);
    if (ctrl_state == 2'd2) fpu_cycles++;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_fpu_op = 0;
    ex_mem_read = 0; ex_mispredict = 0; icache_miss = 0; dcache_miss = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    model_outputs();
    check_all("reset");
    rst = 1'b1;

    // T1 load-use on rs1: one stall cycle, then the bubble clears the hazard
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
    step("t1_stall");
    ex_mem_read = 0;
    step("t1_after");
    // T2 x0 never hazards; unused rs2 never hazards
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    step("t2_x0");
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_use_rs2 = 0;
    step("t2_unused");
    idle_inputs();
    // T3 mispredict in RUN
    ex_mispredict = 1;
    step("t3_flush");
    ex_mispredict = 0;
    step("t3_after");
    // icache miss alone
    icache_miss = 1;
    step("ic_miss");
    icache_miss = 0;
    // T4 FPU op: three FPU_WAIT cycles then RUN
    fpu_cycles = 0;
    id_fpu_op = 1;
    step("t4_issue");
    id_fpu_op = 0;
    repeat (5) step("t4_wait");
    chk("t4_fpu_cycles", 32'(fpu_cycles), 32'd3);
    // T5 dcache miss 5 cycles with mispredict on the first: flush on cycle 6
    dcache_miss = 1; ex_mispredict = 1;
    step("t5_c1");
    ex_mispredict = 0;
    repeat (4) step("t5_hold");
    dcache_miss = 0;
    step("t5_flush");
    step("t5_after");
    // dcache miss during FPU_WAIT freezes the countdown
    fpu_cycles = 0;
    id_fpu_op = 1;
    step("fd_issue");
    id_fpu_op = 0; dcache_miss = 1;
    repeat (2) step("fd_frozen");
    dcache_miss = 0;
    repeat (4) step("fd_resume");
    chk("fd_fpu_cycles", 32'(fpu_cycles), 32'd5);
    // T6 async reset during FPU_WAIT
    id_fpu_op = 1;
    step("t6_issue");
    id_fpu_op = 0;
    step("t6_wait");
    @(negedge clk);
    #2;
    dcache_miss = 1; ex_mispredict = 1;
    rst = 1'b0;
    #1;
    model_reset();
    model_outputs();
    check_all("t6_async");
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    step("t6_release");

    // Random traffic with small register range to provoke hazards
    repeat (400) begin
      id_rs1        = REG_AW'($urandom_range(0, 3));
      id_rs2        = REG_AW'($urandom_range(0, 3));
      ex_rd         = REG_AW'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      id_fpu_op     = ($urandom_range(0, 9) == 0);
      ex_mispredict = ($urandom_range(0, 5) == 0);
      icache_miss   = ($urandom_range(0, 4) == 0);
      dcache_miss   = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
